// File: rtl/fb_ctrl_pipe_pkg.sv
// Shared constants and stage payload types for the fb_ctrl_pipe control unit:
// opcodes, alu_op codes, alu_res_src codes and the mul/div funct7 value.
package fb_ctrl_pipe_pkg;

  localparam int unsigned ALU_OP_BASE_W = 3;
  localparam int unsigned CNT_W         = 4;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [ALU_OP_BASE_W-1:0] ALU_ADD    = 3'd0;
  localparam logic [ALU_OP_BASE_W-1:0] ALU_BR     = 3'd1;
  localparam logic [ALU_OP_BASE_W-1:0] ALU_R      = 3'd2;
  localparam logic [ALU_OP_BASE_W-1:0] ALU_I      = 3'd3;
  localparam logic [ALU_OP_BASE_W-1:0] ALU_MULDIV = 3'd4;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_PC4 = 2'b01;
  localparam logic [1:0] RES_IMM = 2'b10;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [ALU_OP_BASE_W-1:0] alu_op;
    logic                     alu_src;
    logic [1:0]               alu_res_src;
    logic                     pc_src;
    logic                     illegal;
    logic                     mem_read;
    logic                     mem_write;
    logic [1:0]               mem_size;
    logic                     mem_unsigned;
    logic                     branch;
    logic                     mem_to_reg;
    logic                     reg_write;
    logic [4:0]               rd;
  } ctrl_t;

  typedef struct packed {
    logic  valid;
    ctrl_t ctrl;
  } ex_t;

  typedef struct packed {
    logic       valid;
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       branch;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
  } mem_t;

  typedef struct packed {
    logic       valid;
    logic       mem_to_reg;
    logic       reg_write;
    logic [4:0] rd;
  } wb_t;

endpackage

// File: rtl/fb_ctrl_decode.sv
// Combinational ID-stage decoder: maps a 32-bit instruction to the control bundle.
module fb_ctrl_decode
  import fb_ctrl_pipe_pkg::*;
#(
  parameter bit ENABLE_M = 1'b0
) (
  input  logic [31:0] inst,
  output ctrl_t       ctrl_c,
  output logic        muldiv_c
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;
  logic       unused_rs;

  assign opcode    = inst[6:0];
  assign rd        = inst[11:7];
  assign funct3    = inst[14:12];
  assign funct7    = inst[31:25];
  assign unused_rs = ^inst[24:15];

  always_comb begin
    ctrl_c   = '0;
    muldiv_c = 1'b0;
    case (opcode)
      OPC_R: begin
        if (funct7 == F7_MULDIV) begin
          if (ENABLE_M) begin
            ctrl_c.alu_op    = ALU_MULDIV;
            ctrl_c.reg_write = 1'b1;
            muldiv_c         = 1'b1;
          end else begin
            ctrl_c.illegal = 1'b1;
          end
        end else begin
          ctrl_c.alu_op    = ALU_R;
          ctrl_c.reg_write = 1'b1;
        end
      end
      OPC_I: begin
        ctrl_c.alu_op    = ALU_I;
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.reg_write = 1'b1;
      end
      OPC_LOAD: begin
        ctrl_c.alu_src      = 1'b1;
        ctrl_c.mem_read     = 1'b1;
        ctrl_c.mem_size     = funct3[1:0];
        ctrl_c.mem_unsigned = funct3[2];
        ctrl_c.mem_to_reg   = 1'b1;
        ctrl_c.reg_write    = 1'b1;
      end
      OPC_STORE: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.mem_write = 1'b1;
        ctrl_c.mem_size  = funct3[1:0];
      end
      OPC_BRANCH: begin
        ctrl_c.alu_op = ALU_BR;
        ctrl_c.branch = 1'b1;
        ctrl_c.pc_src = 1'b1;
      end
      OPC_JAL: begin
        ctrl_c.alu_res_src = RES_PC4;
        ctrl_c.pc_src      = 1'b1;
        ctrl_c.reg_write   = 1'b1;
      end
      OPC_JALR: begin
        ctrl_c.alu_src     = 1'b1;
        ctrl_c.alu_res_src = RES_PC4;
        ctrl_c.pc_src      = 1'b1;
        ctrl_c.reg_write   = 1'b1;
      end
      OPC_LUI: begin
        ctrl_c.alu_res_src = RES_IMM;
        ctrl_c.reg_write   = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl_c.alu_src   = 1'b1;
        ctrl_c.reg_write = 1'b1;
      end
      default: ctrl_c.illegal = 1'b1;
    endcase
    // x0 is never written; rd is only carried when a write actually happens
    ctrl_c.reg_write = ctrl_c.reg_write & (rd != 5'd0);
    ctrl_c.rd        = ctrl_c.reg_write ? rd : 5'd0;
  end

endmodule

// File: rtl/fb_ctrl_pipe.sv
// Control pipeline: registered EX/MEM/WB control stages with bubble/flush
// handling and an optional multi-cycle mul/div stall FSM.
module fb_ctrl_pipe
  import fb_ctrl_pipe_pkg::*;
#(
  parameter int unsigned ALU_OP_W   = 3,
  parameter bit          ENABLE_M   = 1'b0,
  parameter int unsigned MULDIV_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [31:0]         id_inst,
  input  logic                stall_id,
  input  logic                flush_ex,
  output logic                stall_req,
  output logic                ex_valid,
  output logic [ALU_OP_W-1:0] ex_alu_op,
  output logic                ex_alu_src,
  output logic [1:0]          ex_alu_res_src,
  output logic                ex_pc_src,
  output logic                ex_illegal,
  output logic                mem_valid,
  output logic                mem_read,
  output logic                mem_write,
  output logic [1:0]          mem_size,
  output logic                mem_unsigned,
  output logic                mem_branch,
  output logic                wb_valid,
  output logic                wb_mem_to_reg,
  output logic                wb_reg_write,
  output logic [4:0]          wb_rd
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  ctrl_t            id_ctrl_c;
  logic             id_muldiv_c;
  ex_t              ex_q, ex_d;
  mem_t             mem_q, mem_d, mem_from_ex;
  wb_t              wb_q, wb_d;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  fb_ctrl_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .inst     (id_inst),
    .ctrl_c   (id_ctrl_c),
    .muldiv_c (id_muldiv_c)
  );

  // Stage-to-stage payload narrowing
  always_comb begin
    mem_from_ex.valid        = ex_q.valid;
    mem_from_ex.mem_read     = ex_q.ctrl.mem_read;
    mem_from_ex.mem_write    = ex_q.ctrl.mem_write;
    mem_from_ex.mem_size     = ex_q.ctrl.mem_size;
    mem_from_ex.mem_unsigned = ex_q.ctrl.mem_unsigned;
    mem_from_ex.branch       = ex_q.ctrl.branch;
    mem_from_ex.mem_to_reg   = ex_q.ctrl.mem_to_reg;
    mem_from_ex.reg_write    = ex_q.ctrl.reg_write;
    mem_from_ex.rd           = ex_q.ctrl.rd;
    wb_d.valid               = mem_q.valid;
    wb_d.mem_to_reg          = mem_q.mem_to_reg;
    wb_d.reg_write           = mem_q.reg_write;
    wb_d.rd                  = mem_q.rd;
  end

  // Priority: flush, mul/div busy hold, bubble, normal advance
  always_comb begin
    ex_d    = ex_q;
    mem_d   = mem_from_ex;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush_ex) begin
      ex_d    = '0;
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (state_q == ST_BUSY) begin
      mem_d = '0;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
      end
    end else if (stall_id || !id_valid) begin
      ex_d = '0;
    end else begin
      ex_d.valid = 1'b1;
      ex_d.ctrl  = id_ctrl_c;
      if (ENABLE_M && id_muldiv_c) begin
        state_d = ST_BUSY;
        cnt_d   = CNT_W'(MULDIV_LAT - 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign stall_req      = ENABLE_M && (state_q == ST_BUSY);
  assign ex_valid       = ex_q.valid;
  assign ex_alu_op      = ALU_OP_W'(ex_q.ctrl.alu_op);
  assign ex_alu_src     = ex_q.ctrl.alu_src;
  assign ex_alu_res_src = ex_q.ctrl.alu_res_src;
  assign ex_pc_src      = ex_q.ctrl.pc_src;
  assign ex_illegal     = ex_q.ctrl.illegal;
  assign mem_valid      = mem_q.valid;
  assign mem_read       = mem_q.mem_read;
  assign mem_write      = mem_q.mem_write;
  assign mem_size       = mem_q.mem_size;
  assign mem_unsigned   = mem_q.mem_unsigned;
  assign mem_branch     = mem_q.branch;
  assign wb_valid       = wb_q.valid;
  assign wb_mem_to_reg  = wb_q.mem_to_reg;
  assign wb_reg_write   = wb_q.reg_write;
  assign wb_rd          = wb_q.rd;

endmodule

// File: tb/tb_fb_ctrl_pipe.sv
// Directed bench for fb_ctrl_pipe: one instance with mul/div enabled (LAT=4)
// and one with it disabled, driven from the same inputs.
module tb_fb_ctrl_pipe;

  localparam logic [31:0] I_ADD   = 32'h003100B3;
  localparam logic [31:0] I_ADDX0 = 32'h00310033;
  localparam logic [31:0] I_LW    = 32'h0080A283;
  localparam logic [31:0] I_LBU   = 32'h0040C303;
  localparam logic [31:0] I_SW    = 32'h0020A223;
  localparam logic [31:0] I_JAL   = 32'h008000EF;
  localparam logic [31:0] I_LUI   = 32'h12345137;
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_MUL   = 32'h023100B3;
  localparam logic [31:0] I_BEQ   = 32'h00000063;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall_id, flush_ex;
  logic [31:0] id_inst;

  logic       stall_req, ex_valid, ex_alu_src, ex_pc_src, ex_illegal;
  logic [2:0] ex_alu_op;
  logic [1:0] ex_alu_res_src, mem_size;
  logic       mem_valid, mem_read, mem_write, mem_unsigned, mem_branch;
  logic       wb_valid, wb_mem_to_reg, wb_reg_write;
  logic [4:0] wb_rd;

  logic       z_stall_req, z_ex_valid, z_ex_alu_src, z_ex_pc_src, z_ex_illegal;
  logic [2:0] z_ex_alu_op;
  logic [1:0] z_ex_alu_res_src, z_mem_size;
  logic       z_mem_valid, z_mem_read, z_mem_write, z_mem_unsigned, z_mem_branch;
  logic       z_wb_valid, z_wb_mem_to_reg, z_wb_reg_write;
  logic [4:0] z_wb_rd;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  fb_ctrl_pipe #(.ALU_OP_W(3), .ENABLE_M(1'b1), .MULDIV_LAT(4)) u_dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
    .stall_id(stall_id), .flush_ex(flush_ex), .stall_req(stall_req),
    .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_src(ex_alu_src),
    .ex_alu_res_src(ex_alu_res_src), .ex_pc_src(ex_pc_src), .ex_illegal(ex_illegal),
    .mem_valid(mem_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .mem_branch(mem_branch),
    .wb_valid(wb_valid), .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write),
    .wb_rd(wb_rd)
  );

  fb_ctrl_pipe #(.ALU_OP_W(3), .ENABLE_M(1'b0), .MULDIV_LAT(4)) u_dut_nom (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
    .stall_id(stall_id), .flush_ex(flush_ex), .stall_req(z_stall_req),
    .ex_valid(z_ex_valid), .ex_alu_op(z_ex_alu_op), .ex_alu_src(z_ex_alu_src),
    .ex_alu_res_src(z_ex_alu_res_src), .ex_pc_src(z_ex_pc_src), .ex_illegal(z_ex_illegal),
    .mem_valid(z_mem_valid), .mem_read(z_mem_read), .mem_write(z_mem_write),
    .mem_size(z_mem_size), .mem_unsigned(z_mem_unsigned), .mem_branch(z_mem_branch),
    .wb_valid(z_wb_valid), .wb_mem_to_reg(z_wb_mem_to_reg), .wb_reg_write(z_wb_reg_write),
    .wb_rd(z_wb_rd)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    id_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Present one instruction in ID for a single edge; EX holds it afterwards
  task automatic issue(input logic [31:0] inst);
    id_inst  = inst;
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_op  [5];
    logic       exp_stl [5];
    logic       exp_mv  [5];
    int         stall_cycles;

    rst = 1'b1; id_valid = 1'b0; id_inst = '0; stall_id = 1'b0; flush_ex = 1'b0;
    tick();
    chk("rst_stall_req", stall_req, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_mem_valid", mem_valid, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_rd", wb_rd, 0);
    rst = 1'b0;
    idle(1);

    // add x1,x2,x3
    issue(I_ADD);
    chk("add_ex_valid", ex_valid, 1);
    chk("add_alu_op", ex_alu_op, 3'b010);
    chk("add_alu_src", ex_alu_src, 0);
    tick();
    chk("add_mem_valid", mem_valid, 1);
    chk("add_mem_read", mem_read, 0);
    tick();
    chk("add_wb_reg_write", wb_reg_write, 1);
    chk("add_wb_rd", wb_rd, 1);
    chk("add_wb_m2r", wb_mem_to_reg, 0);

    // lw x5,8(x1)
    issue(I_LW);
    chk("lw_alu_op", ex_alu_op, 3'b000);
    chk("lw_alu_src", ex_alu_src, 1);
    tick();
    chk("lw_mem_read", mem_read, 1);
    chk("lw_mem_size", mem_size, 2'b10);
    chk("lw_mem_unsigned", mem_unsigned, 0);
    tick();
    chk("lw_wb_m2r", wb_mem_to_reg, 1);
    chk("lw_wb_rd", wb_rd, 5);

    // lbu x6,4(x1)
    issue(I_LBU);
    tick();
    chk("lbu_mem_size", mem_size, 2'b00);
    chk("lbu_mem_unsigned", mem_unsigned, 1);

    // sw x2,4(x1)
    issue(I_SW);
    chk("sw_alu_src", ex_alu_src, 1);
    tick();
    chk("sw_mem_write", mem_write, 1);
    chk("sw_mem_read", mem_read, 0);
    chk("sw_mem_size", mem_size, 2'b10);
    tick();
    chk("sw_wb_reg_write", wb_reg_write, 0);

    // jal x1,8 and lui x2
    issue(I_JAL);
    chk("jal_res_src", ex_alu_res_src, 2'b01);
    chk("jal_pc_src", ex_pc_src, 1);
    issue(I_LUI);
    chk("lui_res_src", ex_alu_res_src, 2'b10);
    chk("lui_pc_src", ex_pc_src, 0);
    tick();
    tick();
    chk("lui_wb_rd", wb_rd, 2);

    // add x0 never writes
    issue(I_ADDX0);
    tick();
    tick();
    chk("addx0_wb_valid", wb_valid, 1);
    chk("addx0_wb_reg_write", wb_reg_write, 0);

    // illegal opcode: only the illegal flag set
    issue(I_ILL);
    chk("ill_flag", ex_illegal, 1);
    chk("ill_alu_op", ex_alu_op, 0);
    chk("ill_alu_src", ex_alu_src, 0);
    chk("ill_res_src", ex_alu_res_src, 0);
    chk("ill_pc_src", ex_pc_src, 0);
    tick();
    chk("ill_mem_rw", {mem_read, mem_write, mem_branch, mem_size}, 0);
    tick();
    chk("ill_wb", {wb_reg_write, wb_mem_to_reg, wb_rd}, 0);
    idle(3);

    // mul x1,x2,x3 with an add queued behind it in ID
    exp_op  = '{3'd4, 3'd4, 3'd4, 3'd4, 3'd2};
    exp_stl = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_mv  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    stall_cycles = 0;
    id_inst = I_MUL; id_valid = 1'b1;
    tick();
    chk("nom_mul_illegal", z_ex_illegal, 1);
    chk("nom_stall_req", z_stall_req, 0);
    id_inst = I_ADD;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      if (stall_req) stall_cycles++;
      chk($sformatf("mul_stall_%0d", k), stall_req, exp_stl[k]);
      chk($sformatf("mul_ex_op_%0d", k), ex_alu_op, exp_op[k]);
      chk($sformatf("mul_mem_valid_%0d", k), mem_valid, exp_mv[k]);
    end
    chk("mul_stall_cycles", stall_cycles, 3);
    id_valid = 1'b0;
    tick();
    chk("mul_wb_rd", wb_rd, 1);
    chk("mul_wb_reg_write", wb_reg_write, 1);
    idle(3);

    // beq flushed while add waits in ID
    issue(I_BEQ);
    chk("beq_ex_pc_src", ex_pc_src, 1);
    id_inst = I_ADD; id_valid = 1'b1; flush_ex = 1'b1;
    tick();
    flush_ex = 1'b0; id_valid = 1'b0;
    chk("flush_ex_valid", ex_valid, 0);
    chk("flush_mem_branch", mem_branch, 1);
    tick();
    chk("flush_wb_beq", {wb_valid, wb_reg_write}, 2'b10);
    tick();
    chk("flush_wb_noadd", wb_valid, 0);
    idle(2);

    // flush during mul/div busy
    issue(I_MUL);
    tick();
    chk("fbusy_stall_pre", stall_req, 1);
    flush_ex = 1'b1;
    tick();
    flush_ex = 1'b0;
    chk("fbusy_stall_post", stall_req, 0);
    chk("fbusy_ex_valid", ex_valid, 0);
    idle(3);

    // stall_id for two cycles
    id_inst = I_ADD; id_valid = 1'b1; stall_id = 1'b1;
    tick();
    chk("stl_bubble_0", ex_valid, 0);
    tick();
    chk("stl_bubble_1", ex_valid, 0);
    stall_id = 1'b0;
    tick();
    id_valid = 1'b0;
    chk("stl_ex_valid", ex_valid, 1);
    chk("stl_ex_op", ex_alu_op, 3'b010);
    idle(3);

    // reset while busy
    issue(I_ADD);
    issue(I_MUL);
    tick();
    chk("rbusy_stall_pre", stall_req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rbusy_stall_req", stall_req, 0);
    chk("rbusy_ex", {ex_valid, ex_alu_op}, 0);
    chk("rbusy_mem_valid", mem_valid, 0);
    chk("rbusy_wb", {wb_valid, wb_reg_write, wb_rd}, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_ctrl_pipe.md
Name: fb_ctrl_pipe

Overview:
- Second-generation control unit. Decodes the full 32-bit instruction in ID and carries the resulting control bundle through registered EX, MEM and WB stages.
- Adds, over the combinational decoder:
  - decode of LUI, AUIPC, JAL, load/store widths and illegal opcodes;
  - hazard-driven bubble insertion and branch flush;
  - an optional multi-cycle M-extension stall FSM.
- Sits between the ID stage and the datapath pipeline registers.

Parameters:
- ALU_OP_W, 3, width of the alu_op field; minimum 3.
- ENABLE_M, 0, when 1, decode R-type with funct7=0000001 as mul/div.
- MULDIV_LAT, 4, EX-stage occupancy in cycles of a mul/div op; range 2..15.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  ID holds a real instruction.
- id_inst  in  32  instruction in ID.
- stall_id  in  1  hazard unit: insert a bubble into EX this cycle.
- flush_ex  in  1  control hazard unit: kill EX contents and ID capture.
- stall_req  out  1  mul/div busy; front end must hold IF/ID.
- ex_valid  out  1  EX holds a real instruction.
- ex_alu_op  out  ALU_OP_W  alu opcode.
- ex_alu_src  out  1  0 = rs2/forward, 1 = imm.
- ex_alu_res_src  out  2  00 alu, 01 pc+4 (jal/jalr), 10 imm (lui).
- ex_pc_src  out  1  branch/jal/jalr redirect candidate.
- ex_illegal  out  1  undecodable opcode in EX.
- mem_valid  out  1  MEM holds a real instruction.
- mem_read  out  1  load.
- mem_write  out  1  store.
- mem_size  out  2  funct3[1:0]: byte/half/word.
- mem_unsigned  out  1  funct3[2] for loads.
- mem_branch  out  1  B-type.
- wb_valid  out  1  WB holds a real instruction.
- wb_mem_to_reg  out  1  write-back from memory.
- wb_reg_write  out  1  register write enable.
- wb_rd  out  5  destination register.

Behaviour:
Reset:
- All outputs are 0 on the first clk edge with rst=1, including stall_req.
- FSM goes to IDLE and the counter to 0.

Decode (combinational, in ID):
- alu_op codes:
  - 000: add, for load, store, jalr and auipc.
  - 001: branch compare.
  - 010: R-type.
  - 011: I-ALU.
  - 100: mul/div, only when ENABLE_M=1.
  - All codes are zero-extended to ALU_OP_W.
- alu_src=1 for I-ALU, load, store, jalr and auipc.
- reg_write=1 for R, I-ALU, load, JAL, JALR, LUI and AUIPC, qualified by rd!=0.
- mem_to_reg=1 only for load.
- mem_size and mem_unsigned are meaningful only for load/store; they are 0 otherwise.
- Illegal:
  - any other opcode;
  - R-type with funct7=0000001 while ENABLE_M=0.
  - An illegal instruction yields ex_illegal=1 with all other controls 0.

Pipeline, per cycle, in priority order:
- rst: all stages are cleared.
- flush_ex:
  - EX is loaded with a bubble and the ID instruction is dropped.
  - MEM and WB advance normally.
  - FSM goes to IDLE and stall_req deasserts next cycle.
- FSM BUSY:
  - EX holds its contents.
  - MEM is loaded with a bubble; WB advances from MEM.
  - ID is not captured.
- stall_id, or id_valid=0:
  - EX is loaded with a bubble.
  - MEM and WB advance.
- Otherwise:
  - EX is loaded with the decoded bundle from ID.
  - MEM takes from EX; WB takes from MEM.
- A bubble clears every control bit of the stage, not only its valid bit.
- Single-cycle latency per stage: an instruction captured at edge N is visible on the mem_* outputs after N+1 and on the wb_* outputs after N+2, absent stalls.

Mul/div FSM (present only when ENABLE_M=1; otherwise stall_req is tied 0):
- IDLE → BUSY when an edge loads a valid mul/div into EX. The counter is set to MULDIV_LAT-1 and stall_req is 1 (registered).
- BUSY: the counter decrements each cycle. When the counter reaches 1, the next edge returns the FSM to IDLE with stall_req=0, and the held op advances to MEM on the following edge.
- Total EX residency is exactly MULDIV_LAT cycles.
- A stall_id arriving during BUSY has no additional effect.
- Back-to-back mul/div ops: the second re-enters BUSY immediately on its EX load.

Decomposition:
- Shared constants go in fb_defines.v:
  - opcode values;
  - alu_op codes;
  - alu_res_src codes;
  - mul/div funct7 value.
- One combinational sub-module, fb_ctrl_decode, maps id_inst to the bundle. fb_ctrl_pipe holds the stage registers and the FSM.

Test Plan:
- Reset, then id_inst=0x003100B3 (add x1,x2,x3) with id_valid=1 → next cycle ex_alu_op=010, ex_alu_src=0; two cycles later wb_reg_write=1, wb_rd=1.
- id_inst=0x0080A283 (lw x5,8(x1)) → alu_op=000, alu_src=1, mem_read=1, mem_size=10, mem_unsigned=0, wb_mem_to_reg=1, wb_rd=5.
- Driving add x0 (0x00310033) → wb_reg_write=0. Driving opcode 0x7F → ex_illegal=1 with every other control 0.
- ENABLE_M=1, MULDIV_LAT=4, id_inst=0x023100B3 (mul x1,x2,x3):
  - stall_req=1 for exactly 3 cycles;
  - ex_valid is held for 4 cycles;
  - 3 MEM bubbles appear;
  - mem_valid rises on the 5th cycle after EX load.
- beq 0x00000063 in EX with flush_ex=1 and add waiting in ID → next cycle ex_valid=0 and the add never reaches WB; mem_branch=1 for the beq.
- stall_id=1 for 2 cycles with add in ID → 2 EX bubbles; the add appears in EX afterwards unchanged. Asserting rst mid-BUSY → all outputs 0 and stall_req=0 on the next edge.
